// File: rtl/l2_wb_pkg.sv
// Shared constants and types for the L2 posted-write buffer.
//   AW               : word address width
//   DW               : data width
//   WB_DEPTH_DEFAULT : default number of buffered writes
//   ENTRY_W          : width of one buffered {addr, wdata} entry
//   wb_mode_e        : PASS (buffer empty) / DRAIN (buffer holds writes)
package l2_wb_pkg;

   localparam int AW               = 30;
   localparam int DW               = 32;
   localparam int WB_DEPTH_DEFAULT = 4;
   localparam int ENTRY_W          = AW + DW;

   typedef enum logic {
      MODE_PASS  = 1'b0,
      MODE_DRAIN = 1'b1
   } wb_mode_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding posted writes.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset of pointers and count
//   push   : write din at the tail (ignored when full)
//   pop    : drop the head entry (ignored when empty)
//   din    : entry to push
//   dout   : head entry (valid when not empty)
//   count  : occupied entries, 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
// Push and pop on the same edge are legal: both pointers advance, count holds.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 62
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem[head];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail <= tail + PW'(1);
         if (do_pop)  head <= head + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left out of reset; an entry is
   // only ever read after being written, and a reset memory would not map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= din;
   end

endmodule

// File: rtl/l2_write_buffer.sv
// Posted-write buffer between the processor memory port and the L2 cache.
// Stores are absorbed into a FIFO in one cycle and drained to the L2 in order;
// loads reach the L2 only once the buffer is empty, which preserves
// read-after-write ordering without any address comparison.
//   clk, proc_reset            : clock, synchronous active-high reset
//   proc_read/proc_write       : processor requests, held until accepted
//   proc_addr/proc_wdata       : request address / store data
//   proc_stall                 : request not accepted this cycle (combinational)
//   proc_rdata                 : load data in the accept cycle of a read, else 0
//   l2_read/l2_write           : L2 request strobes
//   l2_addr/l2_wdata/l2_rdata  : L2 address, write data, read data
//   l2_stall                   : L2 busy; request completes on an edge with 0
//   wb_count/wb_empty          : buffer occupancy
module l2_write_buffer
   import l2_wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     proc_reset,
   input  logic                     proc_read,
   input  logic                     proc_write,
   input  logic [AW-1:0]            proc_addr,
   input  logic [DW-1:0]            proc_wdata,
   output logic                     proc_stall,
   output logic [DW-1:0]            proc_rdata,
   output logic                     l2_read,
   output logic                     l2_write,
   output logic [AW-1:0]            l2_addr,
   output logic [DW-1:0]            l2_wdata,
   input  logic [DW-1:0]            l2_rdata,
   input  logic                     l2_stall,
   output logic [$clog2(DEPTH):0]   wb_count,
   output logic                     wb_empty
);

   logic [ENTRY_W-1:0]       head_entry;
   logic [AW-1:0]            head_addr;
   logic [DW-1:0]            head_data;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     push;
   logic                     pop;
   wb_mode_e                 mode;

   assign {head_addr, head_data} = head_entry;

   // A read presented together with a write wins; the write simply stalls.
   // No push at full even if a pop happens on the same edge.
   assign push = !proc_reset && proc_write && !proc_read && !fifo_full;
   assign pop  = !proc_reset && !fifo_empty && !l2_stall;

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (proc_reset),
      .push  (push),
      .pop   (pop),
      .din   ({proc_addr, proc_wdata}),
      .dout  (head_entry),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mode = fifo_empty ? MODE_PASS : MODE_DRAIN;

   // Occupancy reads as empty while reset is held, even before the edge clears it.
   assign wb_count = proc_reset ? '0   : fifo_count;
   assign wb_empty = proc_reset ? 1'b1 : fifo_empty;

   // NOTE: every output gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_addr    = proc_addr;
      l2_wdata   = '0;
      proc_stall = 1'b0;
      proc_rdata = '0;
      if (!proc_reset) begin
         if (mode == MODE_DRAIN) begin
            l2_write = 1'b1;
            l2_addr  = head_addr;
            l2_wdata = head_data;
         end
         if (proc_read) begin
            if (mode == MODE_PASS) begin
               l2_read    = 1'b1;
               l2_addr    = proc_addr;
               proc_stall = l2_stall;
               if (!l2_stall) proc_rdata = l2_rdata;
            end else begin
               // Loads wait for all older stores to reach the L2.
               proc_stall = 1'b1;
            end
         end else if (proc_write) begin
            proc_stall = fifo_full;
         end
      end
   end

endmodule
